// File: rtl/muladd_dot_stream.sv
// Streaming fixed-point dot-product engine: buffers one activation vector,
// then emits one rescaled, saturated result per streamed weight column.
module muladd_dot_stream #(
    parameter int DATA_W   = 16,
    parameter int LANES    = 2,
    parameter int VEC_LEN  = 16,
    parameter int FRAC_W   = 8,
    parameter int ACC_W    = 40,
    parameter int MAX_COLS = 256
) (
    input  logic                            clk_pe,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [$clog2(MAX_COLS+1)-1:0]   cols_i,
    input  logic                            load_en_i,
    output logic                            load_ready_o,
    input  logic [LANES*DATA_W-1:0]         load_payload_i,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic [DATA_W-1:0]               result_payload_o,
    output logic                            result_sat_o,
    output logic                            result_last_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int CNT_W  = $clog2(MAX_COLS + 1);
    localparam int BEATS  = VEC_LEN / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_VEC,
        LOAD_W,
        DRAIN
    } state_t;

    state_t                     state;
    logic [BEAT_W-1:0]          beat;
    logic [CNT_W-1:0]           col;
    logic [CNT_W-1:0]           cols_q;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    lane_sum;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   act [VEC_LEN];
    logic [IDX_W-1:0]           lane_idx [LANES];
    logic signed [2*DATA_W-1:0] prod [LANES];
    logic [DATA_W-1:0]          sat_payload;
    logic                       clip;
    logic [DATA_W-1:0]          out_payload;
    logic                       out_sat;
    logic                       out_last;
    logic                       out_valid;
    logic                       done_q;
    logic                       beat_last;
    logic                       col_last;
    logic                       word_acc;
    logic                       res_acc;

    assign beat_last = (beat == BEAT_W'(BEATS - 1));
    assign col_last  = (col == cols_q - CNT_W'(1));
    assign res_acc   = out_valid && result_ready_i;

    // The closing beat of a column needs the output register free (or
    // being drained on this same edge), otherwise a result would be lost.
    always_comb begin
        load_ready_o = 1'b0;
        unique case (state)
            LOAD_VEC: load_ready_o = 1'b1;
            LOAD_W:   load_ready_o = !(beat_last && out_valid && !result_ready_i);
            default:  load_ready_o = 1'b0;
        endcase
    end

    assign word_acc = load_en_i && load_ready_o;

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = IDX_W'(int'(beat) * LANES + l);
            prod[l] = act[lane_idx[l]] *
                      $signed(load_payload_i[l*DATA_W +: DATA_W]);
            lane_sum = lane_sum + ACC_W'(prod[l]);
        end
    end

    assign acc_next = acc + lane_sum;
    assign shifted  = acc_next >>> FRAC_W;

    always_comb begin
        clip        = 1'b0;
        sat_payload = shifted[DATA_W-1:0];
        if (shifted > MAX_V) begin
            clip        = 1'b1;
            sat_payload = MAX_V[DATA_W-1:0];
        end else if (shifted < MIN_V) begin
            clip        = 1'b1;
            sat_payload = MIN_V[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_pe) begin
        if (state == LOAD_VEC && word_acc) begin
            for (int l = 0; l < LANES; l++) begin
                act[lane_idx[l]] <= $signed(load_payload_i[l*DATA_W +: DATA_W]);
            end
        end
    end

    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            col         <= '0;
            cols_q      <= '0;
            acc         <= '0;
            out_payload <= '0;
            out_sat     <= 1'b0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (res_acc) out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        if (cols_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cols_q <= (cols_i > CNT_W'(MAX_COLS)) ?
                                      CNT_W'(MAX_COLS) : cols_i;
                            beat   <= '0;
                            state  <= LOAD_VEC;
                        end
                    end
                end
                LOAD_VEC: begin
                    if (word_acc) begin
                        if (beat_last) begin
                            beat  <= '0;
                            col   <= '0;
                            acc   <= '0;
                            state <= LOAD_W;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                LOAD_W: begin
                    if (word_acc) begin
                        if (beat_last) begin
                            out_payload <= sat_payload;
                            out_sat     <= clip;
                            out_last    <= col_last;
                            out_valid   <= 1'b1;
                            acc         <= '0;
                            beat        <= '0;
                            col         <= col + CNT_W'(1);
                            if (col_last) state <= DRAIN;
                        end else begin
                            acc  <= acc_next;
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (res_acc) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result_valid_o   = out_valid;
    assign result_payload_o = out_payload;
    assign result_sat_o     = out_sat;
    assign result_last_o    = out_last;
    assign busy_o           = (state != IDLE);
    assign done_o           = done_q;

endmodule
